pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; reset polarity and synchronicity are fixed.
REQ-002 Parameters SHALL be:
- REG_ADDR_W, default 5, register address width.
- FWD_EN, default 1, 1 = forwarding mode, 0 = interlock-only mode.
- LOAD_STALL_CYCLES, default 1, range 1..3, load-use bubbles per hazard.
- MEM_TIMEOUT, default 64, maximum memory wait cycles before error.
- CNT_W, default 16, stall counter width.
REQ-003 Ports SHALL be:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- RS1_D, RS2_D  in  REG_ADDR_W  decode source registers
- RS1_E, RS2_E, RD_E  in  REG_ADDR_W  execute sources and destination
- RD_M, RD_W  in  REG_ADDR_W  memory and writeback destinations
- REG_W_En_E, REG_W_En_M, REG_W_En_W  in  1  register write enables per stage
- Result_Src_Sel_E  in  2  result source; 2'h1 = load
- Branch_Taken_E, Predict_Taken_E  in  1  branch resolution and prediction
- Mem_Req_M, Mem_Ready_M  in  1  data memory request and ready
- FWD_SrcA, FWD_SrcB  out  2  forwarding selects: 00 none, 01 writeback, 10 memory
- PC_En, Stall_D, Stall_E, Stall_M  out  1  stage hold enables
- Flush_D, Flush_E, Flush_W  out  1  bubble insertion into IF/ID, ID/EX, MEM/WB
- Mem_Err  out  1  sticky memory-timeout flag
- Stall_Count  out  CNT_W  saturating count of stalled cycles

Function
REQ-004 FWD_EN=1: FWD_SrcA SHALL be 10 if RS1_E!=0 && REG_W_En_M && RD_M==RS1_E; else 01 if RS1_E!=0 && REG_W_En_W && RD_W==RS1_E; else 00. FWD_SrcB SHALL follow the same rule on RS2_E.
REQ-005 FWD_EN=0: FWD_SrcA/B SHALL be 00; a RAW stall SHALL be raised when a nonzero RS1_D/RS2_D equals RD_E with REG_W_En_E set, or equals RD_M with REG_W_En_M set.
REQ-006 A load-use hazard SHALL be raised when Result_Src_Sel_E==2'h1 && RD_E!=0 && (RD_E==RS1_D || RD_E==RS2_D), in both modes.
REQ-007 An FSM SHALL have states RUN, LOAD_STALL and MEM_WAIT.
REQ-008 In RUN, a load-use or RAW hazard SHALL drive PC_En=0, Stall_D=1 and Flush_E=1 combinationally in the same cycle.
REQ-009 If LOAD_STALL_CYCLES>1, a load-use hazard SHALL move the FSM to LOAD_STALL for LOAD_STALL_CYCLES-1 further cycles, counted down by a counter, with the same outputs held unconditionally; the FSM SHALL then return to RUN.
REQ-010 A mispredict (Branch_Taken_E!=Predict_Taken_E) SHALL drive Flush_D=1, Flush_E=1 and PC_En=1, SHALL override any load-use or RAW stall in that cycle, and SHALL abort LOAD_STALL to RUN.
REQ-011 Mem_Req_M && !Mem_Ready_M SHALL have top priority and move the FSM to MEM_WAIT from any state.
REQ-012 In MEM_WAIT and in the detecting cycle, outputs SHALL be PC_En=0, Stall_D=Stall_E=Stall_M=1, Flush_W=1 and Flush_D=Flush_E=0; a mispredict or hazard is deferred, not lost.
REQ-013 MEM_WAIT SHALL exit to RUN in the cycle after Mem_Ready_M is sampled high; pending LOAD_STALL cycles SHALL be discarded, because the hazard is re-detected combinationally.
REQ-014 A wait counter SHALL count MEM_WAIT cycles. On reaching MEM_TIMEOUT it SHALL set Mem_Err=1 (sticky until reset), force exit to RUN and clear the counter.
REQ-015 Stall_Count SHALL increment in every cycle with PC_En=0 and RST low, and SHALL saturate at all-ones without wrapping.
REQ-016 With no hazard, mispredict or wait, outputs SHALL be PC_En=1, every Stall_*=0 and every Flush_*=0.

Reset
REQ-017 While RST is high, the FSM SHALL be in RUN and all counters SHALL be 0; the state SHALL be cleared asynchronously, including mid-stall and mid-wait.
REQ-018 While RST is high, outputs SHALL be PC_En=0, Flush_D=Flush_E=Flush_W=1, Stall_*=0, FWD_Src*=00, Mem_Err=0 and Stall_Count=0.
REQ-019 In the first cycle after RST deasserts, outputs SHALL follow REQ-016 unless an input condition applies.

Verification
REQ-020 The bench SHALL cover forwarding with FWD_EN=1, RS1_E=5, RD_M=5, REG_W_En_M=1, RS2_E=7, RD_W=7, REG_W_En_W=1 -> FWD_SrcA=10, FWD_SrcB=01, PC_En=1; then RS1_E=0 with RD_M=0 -> FWD_SrcA=00.
REQ-021 The bench SHALL cover load-use with LOAD_STALL_CYCLES=2, Result_Src_Sel_E=1, RD_E=3, RS2_D=3 -> exactly 2 cycles of PC_En=0, Stall_D=1, Flush_E=1, then RUN, with Stall_Count incremented by 2.
REQ-022 The bench SHALL cover a mispredict during a load-use hazard, Branch_Taken_E=1 and Predict_Taken_E=0 -> Flush_D=Flush_E=1, PC_En=1, Stall_D=0.
REQ-023 The bench SHALL cover a memory wait with Mem_Req_M=1 and Mem_Ready_M=0 for 4 cycles while a mispredict is present -> Stall_D/E/M=1, Flush_W=1, Flush_D=0; after Mem_Ready_M=1 -> the flush is applied the next cycle.
REQ-024 The bench SHALL cover timeout with MEM_TIMEOUT=8 and Mem_Ready_M held 0 -> Mem_Err=1 after 8 cycles; Mem_Err SHALL stay 1 until RST, then be 0.
REQ-025 The bench SHALL cover FWD_EN=0 with RS1_D=9, RD_E=9, REG_W_En_E=1 -> a 1-cycle stall, FWD_SrcA=00; and RST asserted mid-MEM_WAIT -> immediate return to the REQ-018 values.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use/RAW bubbles,
// mispredict flushes and data-memory wait handling with a sticky timeout flag.
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W        = 5,
    parameter int FWD_EN            = 1,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 64,
    parameter int CNT_W             = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_ADDR_W-1:0] RS1_D,
    input  logic [REG_ADDR_W-1:0] RS2_D,
    input  logic [REG_ADDR_W-1:0] RS1_E,
    input  logic [REG_ADDR_W-1:0] RS2_E,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic [REG_ADDR_W-1:0] RD_M,
    input  logic [REG_ADDR_W-1:0] RD_W,
    input  logic                  REG_W_En_E,
    input  logic                  REG_W_En_M,
    input  logic                  REG_W_En_W,
    input  logic [1:0]            Result_Src_Sel_E,
    input  logic                  Branch_Taken_E,
    input  logic                  Predict_Taken_E,
    input  logic                  Mem_Req_M,
    input  logic                  Mem_Ready_M,
    output logic [1:0]            FWD_SrcA,
    output logic [1:0]            FWD_SrcB,
    output logic                  PC_En,
    output logic                  Stall_D,
    output logic                  Stall_E,
    output logic                  Stall_M,
    output logic                  Flush_D,
    output logic                  Flush_E,
    output logic                  Flush_W,
    output logic                  Mem_Err,
    output logic [CNT_W-1:0]      Stall_Count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam int                    WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [1:0]            LS_INIT   = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG  = {REG_ADDR_W{1'b0}};

    state_t            state_r, state_s;
    logic [1:0]        ls_cnt_r, ls_cnt_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
    logic              mem_err_r, mem_err_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic       load_use_s, raw_s, mispredict_s, mem_miss_s;
    logic [1:0] fwd_a_s, fwd_b_s;
    logic       pc_en_s, stall_d_s, stall_e_s, stall_m_s;
    logic       flush_d_s, flush_e_s, flush_w_s;

    // Memory stage wins over writeback because it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input logic                  we_m,
                                           input logic [REG_ADDR_W-1:0] rd_m,
                                           input logic                  we_w,
                                           input logic [REG_ADDR_W-1:0] rd_w);
        logic [1:0] sel;
        if (rs == ZERO_REG) begin
            sel = 2'b00;
        end else if (we_m && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic raw_hit(input logic [REG_ADDR_W-1:0] rs,
                                     input logic                  we_e,
                                     input logic [REG_ADDR_W-1:0] rd_e,
                                     input logic                  we_m,
                                     input logic [REG_ADDR_W-1:0] rd_m);
        return (rs != ZERO_REG) && ((we_e && (rd_e == rs)) || (we_m && (rd_m == rs)));
    endfunction

    assign load_use_s   = (Result_Src_Sel_E == 2'h1) && (RD_E != ZERO_REG) &&
                          ((RD_E == RS1_D) || (RD_E == RS2_D));
    assign raw_s        = (FWD_EN == 0) &&
                          (raw_hit(RS1_D, REG_W_En_E, RD_E, REG_W_En_M, RD_M) ||
                           raw_hit(RS2_D, REG_W_En_E, RD_E, REG_W_En_M, RD_M));
    assign mispredict_s = (Branch_Taken_E != Predict_Taken_E);
    assign mem_miss_s   = Mem_Req_M && !Mem_Ready_M;

    // Next-state and stage control; reset overrides the outputs at the end.
    always_comb begin
        state_s    = state_r;
        ls_cnt_s   = ls_cnt_r;
        wait_cnt_s = wait_cnt_r;
        mem_err_s  = mem_err_r;
        pc_en_s    = 1'b1;
        stall_d_s  = 1'b0;
        stall_e_s  = 1'b0;
        stall_m_s  = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        flush_w_s  = 1'b0;
        if (FWD_EN != 0) begin
            fwd_a_s = fwd_sel(RS1_E, REG_W_En_M, RD_M, REG_W_En_W, RD_W);
            fwd_b_s = fwd_sel(RS2_E, REG_W_En_M, RD_M, REG_W_En_W, RD_W);
        end else begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end

        case (state_r)
            RUN, LOAD_STALL: begin
                if (mem_miss_s) begin
                    // Any deferred hazard is re-detected once memory answers.
                    pc_en_s    = 1'b0;
                    stall_d_s  = 1'b1;
                    stall_e_s  = 1'b1;
                    stall_m_s  = 1'b1;
                    flush_w_s  = 1'b1;
                    state_s    = MEM_WAIT;
                    ls_cnt_s   = 2'd0;
                    wait_cnt_s = {WAIT_W{1'b0}};
                end else if (mispredict_s) begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    state_s   = RUN;
                    ls_cnt_s  = 2'd0;
                end else if (state_r == LOAD_STALL) begin
                    pc_en_s   = 1'b0;
                    stall_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    if (ls_cnt_r <= 2'd1) begin
                        state_s  = RUN;
                        ls_cnt_s = 2'd0;
                    end else begin
                        ls_cnt_s = ls_cnt_r - 2'd1;
                    end
                end else if (load_use_s || raw_s) begin
                    pc_en_s   = 1'b0;
                    stall_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    if (load_use_s && (LOAD_STALL_CYCLES > 1)) begin
                        state_s  = LOAD_STALL;
                        ls_cnt_s = LS_INIT;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            MEM_WAIT: begin
                pc_en_s   = 1'b0;
                stall_d_s = 1'b1;
                stall_e_s = 1'b1;
                stall_m_s = 1'b1;
                flush_w_s = 1'b1;
                if (!mem_miss_s) begin
                    state_s    = RUN;
                    wait_cnt_s = {WAIT_W{1'b0}};
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s    = RUN;
                    mem_err_s  = 1'b1;
                    wait_cnt_s = {WAIT_W{1'b0}};
                end else begin
                    wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            default: begin
                state_s    = RUN;
                ls_cnt_s   = 2'd0;
                wait_cnt_s = {WAIT_W{1'b0}};
            end
        endcase

        if (RST) begin
            pc_en_s   = 1'b0;
            stall_d_s = 1'b0;
            stall_e_s = 1'b0;
            stall_m_s = 1'b0;
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
            flush_w_s = 1'b1;
            fwd_a_s   = 2'b00;
            fwd_b_s   = 2'b00;
        end else begin
            state_s = state_s;
        end
    end

    // FSM state, bubble/wait counters and sticky timeout flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= RUN;
            ls_cnt_r   <= 2'd0;
            wait_cnt_r <= {WAIT_W{1'b0}};
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            ls_cnt_r   <= ls_cnt_s;
            wait_cnt_r <= wait_cnt_s;
            mem_err_r  <= mem_err_s;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!pc_en_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign FWD_SrcA    = fwd_a_s;
    assign FWD_SrcB    = fwd_b_s;
    assign PC_En       = pc_en_s;
    assign Stall_D     = stall_d_s;
    assign Stall_E     = stall_e_s;
    assign Stall_M     = stall_m_s;
    assign Flush_D     = flush_d_s;
    assign Flush_E     = flush_e_s;
    assign Flush_W     = flush_w_s;
    assign Mem_Err     = mem_err_r;
    assign Stall_Count = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: one forwarding instance and one interlock-only instance
// share stimulus; vector table, directed corner sequences and a random run.
module tb_pipeline_hazard_controller;

    localparam int AW  = 5;
    localparam int LSC = 2;
    localparam int TO  = 8;

    // Packed output order: {fwdA, fwdB, pc_en, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    localparam logic [10:0] O_RUN   = {4'b0000, 1'b1, 3'b000, 3'b000};
    localparam logic [10:0] O_BUB   = {4'b0000, 1'b0, 3'b100, 3'b010};
    localparam logic [10:0] O_FLUSH = {4'b0000, 1'b1, 3'b000, 3'b110};
    localparam logic [10:0] O_MEMW  = {4'b0000, 1'b0, 3'b111, 3'b001};
    localparam logic [10:0] O_RST   = {4'b0000, 1'b0, 3'b000, 3'b111};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          we_e, we_m, we_w, bt, pt, req, rdy;
    logic [1:0]    rsel;

    logic [1:0]  a_fa, a_fb, b_fa, b_fb;
    logic        a_pc, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_err;
    logic        b_pc, b_sd, b_se, b_sm, b_fd, b_fe, b_fw, b_err;
    logic [15:0] a_cnt, b_cnt;
    logic [10:0] a_o, b_o;

    assign a_o = {a_fa, a_fb, a_pc, a_sd, a_se, a_sm, a_fd, a_fe, a_fw};
    assign b_o = {b_fa, b_fb, b_pc, b_sd, b_se, b_sm, b_fd, b_fe, b_fw};

    pipeline_hazard_controller #(.REG_ADDR_W(AW), .FWD_EN(1), .LOAD_STALL_CYCLES(LSC),
                                 .MEM_TIMEOUT(TO), .CNT_W(16)) u_fwd (
        .CLK(clk), .RST(rst), .RS1_D(rs1_d), .RS2_D(rs2_d), .RS1_E(rs1_e), .RS2_E(rs2_e),
        .RD_E(rd_e), .RD_M(rd_m), .RD_W(rd_w), .REG_W_En_E(we_e), .REG_W_En_M(we_m),
        .REG_W_En_W(we_w), .Result_Src_Sel_E(rsel), .Branch_Taken_E(bt), .Predict_Taken_E(pt),
        .Mem_Req_M(req), .Mem_Ready_M(rdy), .FWD_SrcA(a_fa), .FWD_SrcB(a_fb), .PC_En(a_pc),
        .Stall_D(a_sd), .Stall_E(a_se), .Stall_M(a_sm), .Flush_D(a_fd), .Flush_E(a_fe),
        .Flush_W(a_fw), .Mem_Err(a_err), .Stall_Count(a_cnt));

    pipeline_hazard_controller #(.REG_ADDR_W(AW), .FWD_EN(0), .LOAD_STALL_CYCLES(LSC),
                                 .MEM_TIMEOUT(TO), .CNT_W(16)) u_ilk (
        .CLK(clk), .RST(rst), .RS1_D(rs1_d), .RS2_D(rs2_d), .RS1_E(rs1_e), .RS2_E(rs2_e),
        .RD_E(rd_e), .RD_M(rd_m), .RD_W(rd_w), .REG_W_En_E(we_e), .REG_W_En_M(we_m),
        .REG_W_En_W(we_w), .Result_Src_Sel_E(rsel), .Branch_Taken_E(bt), .Predict_Taken_E(pt),
        .Mem_Req_M(req), .Mem_Ready_M(rdy), .FWD_SrcA(b_fa), .FWD_SrcB(b_fb), .PC_En(b_pc),
        .Stall_D(b_sd), .Stall_E(b_se), .Stall_M(b_sm), .Flush_D(b_fd), .Flush_E(b_fe),
        .Flush_W(b_fw), .Mem_Err(b_err), .Stall_Count(b_cnt));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        we_e = 1'b0; we_m = 1'b0; we_w = 1'b0; rsel = 2'd0;
        bt = 1'b0; pt = 1'b0; req = 1'b0; rdy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Reference model: pipeline-level bookkeeping per instance (0 = forwarding, 1 = interlock).
    bit waiting [2];
    int wait_n  [2];
    int left    [2];
    bit err     [2];
    int cnt     [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            waiting[m] = 1'b0; wait_n[m] = 0; left[m] = 0; err[m] = 1'b0; cnt[m] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        #1;
        chk("rst_a", a_o, O_RST);
        chk("rst_b", b_o, O_RST);
        chk("rst_err", a_err, 1'b0);
        chk("rst_cnt", a_cnt, 16'd0);
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    function automatic bit depends(input logic [AW-1:0] rs);
        return (rs != 5'd0) && ((we_e && rd_e == rs) || (we_m && rd_m == rs));
    endfunction

    function automatic logic [1:0] producer(input logic [AW-1:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (we_m && rd_m == rs) return 2'b10;
        if (we_w && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit load_use();
        return (rsel == 2'd1) && (rd_e != 5'd0) && (rd_e == rs1_d || rd_e == rs2_d);
    endfunction

    function automatic logic [10:0] model_out(input int m);
        bit          miss = req && !rdy;
        bit          raw  = (m == 1) && (depends(rs1_d) || depends(rs2_d));
        logic [10:0] base;
        if (waiting[m] || miss) base = O_MEMW;
        else if (bt != pt)      base = O_FLUSH;
        else if (left[m] > 0 || load_use() || raw) base = O_BUB;
        else base = O_RUN;
        if (m == 0) base = base | {producer(rs1_e), producer(rs2_e), 7'd0};
        return base;
    endfunction

    task automatic model_step(input int m, input logic pc);
        bit miss = req && !rdy;
        if (!pc) cnt[m] = (cnt[m] == 65535) ? 65535 : cnt[m] + 1;
        if (waiting[m]) begin
            left[m] = 0;
            if (!miss) begin
                waiting[m] = 1'b0; wait_n[m] = 0;
            end else if (wait_n[m] + 1 == TO) begin
                err[m] = 1'b1; waiting[m] = 1'b0; wait_n[m] = 0;
            end else begin
                wait_n[m]++;
            end
        end else if (miss) begin
            waiting[m] = 1'b1; left[m] = 0; wait_n[m] = 0;
        end else if (bt != pt) begin
            left[m] = 0;
        end else if (left[m] > 0) begin
            left[m]--;
        end else if (load_use()) begin
            left[m] = LSC - 1;
        end
    endtask

    typedef struct packed {
        logic          fwd;
        logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic          we_e, we_m, we_w;
        logic [1:0]    rsel;
        logic          bt, pt, req, rdy;
        logic [10:0]   exp;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{1'b1, 5'd0, 5'd0, 5'd5, 5'd7, 5'd0, 5'd5, 5'd7, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN | {4'b1001, 7'd0}};
        vt[1]  = '{1'b1, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN | {4'b0001, 7'd0}};
        vt[2]  = '{1'b1, 5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd4, 5'd4, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN | {4'b1010, 7'd0}};
        vt[3]  = '{1'b1, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd6, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN | {4'b0100, 7'd0}};
        vt[4]  = '{1'b0, 5'd0, 5'd0, 5'd5, 5'd7, 5'd0, 5'd5, 5'd7, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
        vt[5]  = '{1'b0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_BUB};
        vt[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
        vt[7]  = '{1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN};
        vt[8]  = '{1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
        vt[9]  = '{1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_FLUSH};
        vt[10] = '{1'b1, 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, O_MEMW};
        vt[11] = '{1'b0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, O_FLUSH};

        rst = 1'b1;
        idle();
        #2;
        chk("init_rst_a", a_o, O_RST);
        chk("init_rst_b", b_o, O_RST);

        // Single-cycle vector table, each from a fresh reset
        for (int i = 0; i < 12; i++) begin
            do_reset();
            rs1_d = vt[i].rs1_d; rs2_d = vt[i].rs2_d; rs1_e = vt[i].rs1_e; rs2_e = vt[i].rs2_e;
            rd_e = vt[i].rd_e; rd_m = vt[i].rd_m; rd_w = vt[i].rd_w;
            we_e = vt[i].we_e; we_m = vt[i].we_m; we_w = vt[i].we_w; rsel = vt[i].rsel;
            bt = vt[i].bt; pt = vt[i].pt; req = vt[i].req; rdy = vt[i].rdy;
            settle();
            chk($sformatf("vec%0d", i), vt[i].fwd ? a_o : b_o, vt[i].exp);
        end

        // Load-use with two bubbles, second one held with hazard gone
        do_reset();
        rsel = 2'd1; rd_e = 5'd3; rs2_d = 5'd3;
        settle(); chk("lu_c1", a_o, O_BUB); chk("lu_c1_cnt", a_cnt, 16'd0);
        tick(); idle();
        settle(); chk("lu_c2", a_o, O_BUB);
        tick();
        settle(); chk("lu_c3", a_o, O_RUN); chk("lu_cnt", a_cnt, 16'd2);

        // Mispredict beats load-use; mispredict aborts a pending bubble
        do_reset();
        rsel = 2'd1; rd_e = 5'd3; rs2_d = 5'd3; bt = 1'b1; pt = 1'b0;
        settle(); chk("mp_lu", a_o, O_FLUSH);
        tick(); idle();
        settle(); chk("mp_lu_next", a_o, O_RUN);
        tick(); rsel = 2'd1; rd_e = 5'd3; rs2_d = 5'd3;
        settle(); chk("abort_c1", a_o, O_BUB);
        tick(); idle(); bt = 1'b1;
        settle(); chk("abort_c2", a_o, O_FLUSH);
        tick(); idle();
        settle(); chk("abort_c3", a_o, O_RUN);

        // Memory wait with a deferred mispredict
        do_reset();
        req = 1'b1; rdy = 1'b0; bt = 1'b1; pt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle(); chk($sformatf("mw_hold%0d", k), a_o, O_MEMW);
            tick();
        end
        rdy = 1'b1;
        settle(); chk("mw_ready", a_o, O_MEMW);
        tick(); req = 1'b0; rdy = 1'b0;
        settle(); chk("mw_flush", a_o, O_FLUSH); chk("mw_cnt", a_cnt, 16'd5);
        tick(); idle();
        settle(); chk("mw_after", a_o, O_RUN);

        // Timeout: detect cycle plus TO wait cycles, then sticky error
        do_reset();
        req = 1'b1; rdy = 1'b0;
        for (int k = 0; k <= TO; k++) begin
            settle(); chk($sformatf("to_noerr%0d", k), a_err, 1'b0);
            tick();
        end
        settle(); chk("to_err", a_err, 1'b1);
        tick(); idle();
        settle(); chk("to_sticky", a_err, 1'b1);
        tick();
        settle(); chk("to_sticky2", a_err, 1'b1); chk("to_run", a_o, O_RUN);
        do_reset();
        settle(); chk("to_cleared", a_err, 1'b0);

        // Interlock-only RAW stall, forwarding instance forwards instead
        do_reset();
        rs1_d = 5'd9; rd_e = 5'd9; we_e = 1'b1; rs1_e = 5'd9; rd_m = 5'd9; we_m = 1'b1;
        settle(); chk("raw_ilk", b_o, O_BUB); chk("raw_fwd", a_o, O_RUN | {4'b1000, 7'd0});
        tick(); idle();
        settle(); chk("raw_ilk_next", b_o, O_RUN); chk("raw_ilk_cnt", b_cnt, 16'd1);

        // Asynchronous reset in the middle of a memory wait
        do_reset();
        req = 1'b1; rdy = 1'b0;
        tick(); tick(); tick();
        settle(); chk("mwr_wait", a_o, O_MEMW);
        #2 rst = 1'b1;
        #1;
        chk("mwr_a", a_o, O_RST); chk("mwr_b", b_o, O_RST);
        chk("mwr_cnt", a_cnt, 16'd0); chk("mwr_err", a_err, 1'b0);
        tick(); rst = 1'b0; idle();
        settle(); chk("post_rst_a", a_o, O_RUN); chk("post_rst_b", b_o, O_RUN);

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            we_e = 1'($urandom_range(0, 1)); we_m = 1'($urandom_range(0, 1));
            we_w = 1'($urandom_range(0, 1)); rsel = 2'($urandom_range(0, 3));
            bt = ($urandom_range(0, 3) == 0); pt = 1'b0;
            req = ($urandom_range(0, 3) == 0); rdy = 1'($urandom_range(0, 1));
            settle();
            for (int m = 0; m < 2; m++) begin
                logic [10:0] e;
                e = model_out(m);
                chk($sformatf("rand%0d_m%0d_out", i, m), (m == 0) ? a_o : b_o, e);
                chk($sformatf("rand%0d_m%0d_cnt", i, m), (m == 0) ? a_cnt : b_cnt, cnt[m]);
                chk($sformatf("rand%0d_m%0d_err", i, m), (m == 0) ? a_err : b_err, err[m]);
                model_step(m, e[6]);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
